// File: rtl/spi_ovr_jtag_pkg.sv
// Shared definitions for the JTAG-to-SPI header bridge: FSM state encoding
// and the default header width.
package spi_ovr_jtag_pkg;

    localparam int HDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_XFER,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_hdr_bridge_if.sv
// JTAG user-register strobes from the TAP side and the flash SPI pins,
// bundled between the BSCAN/STARTUP wrapper and the bridge.
interface spi_hdr_bridge_if;

    logic jtag_sel;
    logic jtag_capture;
    logic jtag_shift;
    logic jtag_update;
    logic jtag_tdi;
    logic jtag_tdo;
    logic spi_csn;
    logic spi_sck_en;
    logic spi_mosi;
    logic spi_miso;
    logic busy;
    logic abort_err;

    modport slave (
        input  jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_tdi, spi_miso,
        output jtag_tdo, spi_csn, spi_sck_en, spi_mosi, busy, abort_err
    );

    modport master (
        output jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_tdi, spi_miso,
        input  jtag_tdo, spi_csn, spi_sck_en, spi_mosi, busy, abort_err
    );

endinterface

// File: rtl/spi_hdr_counter.sv
// Loadable payload bit down-counter; saturates at zero instead of wrapping.
module spi_hdr_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero
);

    assign is_zero = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !is_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/spi_hdr_bridge.sv
// JTAG USER-register to SPI flash bridge: an HDR_W-bit LSB-first length header
// is shifted in, then exactly that many scan bits are passed through to the flash.
module spi_hdr_bridge
    import spi_ovr_jtag_pkg::*;
#(
    parameter int HDR_W = HDR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_hdr_bridge_if.slave  bus
);

    localparam int HC_W = $clog2(HDR_W + 1);

    state_e            state_q, state_d;
    logic [HDR_W-1:0]  hdr_q, hdr_shifted, cnt;
    logic [HC_W-1:0]   hdr_cnt_q;
    logic              cnt_zero, cnt_one, hdr_last;
    logic              cap, upd, sh;

    // Capture outranks update, which outranks shift; nothing acts without jtag_sel.
    assign cap = bus.jtag_sel & bus.jtag_capture;
    assign upd = bus.jtag_sel & bus.jtag_update & ~cap;
    assign sh  = bus.jtag_sel & bus.jtag_shift & ~cap & ~upd;

    assign hdr_shifted = {bus.jtag_tdi, hdr_q[HDR_W-1:1]};
    assign hdr_last    = (hdr_cnt_q == HC_W'(HDR_W - 1));
    assign cnt_one     = (cnt == HDR_W'(1));

    spi_hdr_counter #(.W(HDR_W)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cap),
        .load     (sh && state_q == ST_HDR && hdr_last),
        .load_val (hdr_shifted),
        .dec      (sh && state_q == ST_XFER),
        .count    (cnt),
        .is_zero  (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (cap) begin
            state_d = ST_HDR;
        end else if (upd) begin
            state_d = ST_IDLE;
        end else if (sh) begin
            case (state_q)
                ST_HDR:  if (hdr_last) state_d = (hdr_shifted == '0) ? ST_DONE : ST_XFER;
                ST_XFER: if (cnt_one)  state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bus.busy       = (state_q == ST_HDR) || (state_q == ST_XFER);
        bus.spi_sck_en = 1'b0;
        bus.spi_mosi   = 1'b1;
        bus.jtag_tdo   = 1'b0;
        if (state_q == ST_XFER) begin
            bus.spi_sck_en = bus.jtag_sel & bus.jtag_shift;
            bus.spi_mosi   = bus.jtag_tdi;
            bus.jtag_tdo   = bus.spi_miso;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
        end else if (cap) begin
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
        end else if (sh && state_q == ST_HDR) begin
            hdr_q     <= hdr_shifted;
            hdr_cnt_q <= hdr_cnt_q + HC_W'(1);
        end
    end

    // Chip select drops on the header-completing edge so the very next shift is payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.spi_csn   <= 1'b1;
            bus.abort_err <= 1'b0;
        end else if (cap) begin
            bus.spi_csn   <= 1'b1;
            bus.abort_err <= 1'b0;
        end else if (upd) begin
            if (state_q == ST_XFER) begin
                bus.spi_csn <= 1'b1;
                if (!cnt_zero) bus.abort_err <= 1'b1;
            end
        end else if (sh) begin
            if (state_q == ST_HDR && hdr_last && hdr_shifted != '0) bus.spi_csn <= 1'b0;
            if (state_q == ST_XFER && cnt_one)                     bus.spi_csn <= 1'b1;
        end
    end

endmodule

// File: doc/spi_hdr_bridge.md
SPI_HDR_BRIDGE -- requirements
Module: spi_hdr_bridge

Interface
REQ-001 Parameter HDR_W, default 16: width of the length header (payload bit count) preceding each SPI transfer.
REQ-002 clk  in  1  gated JTAG clock (DRCK of the USER1 BSCAN); one clock, all state on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 jtag_sel  in  1  USER1 instruction active; all jtag_* strobes are ignored while low.
REQ-005 jtag_capture  in  1  TAP in Capture-DR.
REQ-006 jtag_shift  in  1  TAP in Shift-DR.
REQ-007 jtag_update  in  1  TAP in Update-DR.
REQ-008 jtag_tdi  in  1  scan data from TAP, LSB first.
REQ-009 jtag_tdo  out  1  scan data to TAP.
REQ-010 spi_csn  out  1  flash chip select, registered, active low.
REQ-011 spi_sck_en  out  1  clock-gate enable for flash CCLK (consumer gates clk with it).
REQ-012 spi_mosi  out  1  flash DQ0.
REQ-013 spi_miso  in  1  flash DQ1.
REQ-014 busy  out  1  high while in HDR or XFER.
REQ-015 abort_err  out  1  sticky flag: transfer truncated by Update-DR.

Function
REQ-016 FSM states IDLE, HDR, XFER, DONE; the state register and all registered outputs update on the rising clk edge only.
REQ-017 Strobes are qualified by jtag_sel; priority is capture > update > shift.
REQ-018 Capture in any state: go to HDR, clear the header shift register and bit counter, set spi_csn=1, clear abort_err.
REQ-019 HDR: each shift cycle shifts jtag_tdi into the header register LSB-first; the HDR_W-th shift cycle completes the header.
REQ-020 Header complete with value N=0: go to DONE, spi_csn stays 1.
REQ-021 Header complete with N>0: load the bit counter with N, go to XFER, and drive spi_csn=0 from the same edge; the first payload bit is the next shift cycle.
REQ-022 XFER: spi_sck_en = jtag_sel & jtag_shift (combinational); spi_mosi = jtag_tdi; jtag_tdo = spi_miso; each shift cycle decrements the counter.
REQ-023 XFER shift cycle with counter==1: spi_csn=1 and go to DONE at that edge, so exactly N SCK pulses are produced.
REQ-024 Outside XFER: spi_sck_en=0, spi_mosi=1, jtag_tdo=0.
REQ-025 Update in XFER (counter>0): set spi_csn=1 and abort_err=1, go to IDLE.
REQ-026 Update in HDR, DONE or IDLE: go to IDLE; abort_err is unchanged.
REQ-027 Shift in IDLE or DONE is ignored; extra scan bits after N are discarded.
REQ-028 N = 2^HDR_W-1 is legal; the counter is HDR_W bits wide with no wrap (it stops at 0).

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, spi_csn=1, abort_err=0, busy=0, header register=0, counter=0.
REQ-030 Reset asserted during XFER raises spi_csn immediately; no SCK enable is produced until a new Capture.

Structure
REQ-031 The state enum and the HDR_W default value are kept in the shared package spi_ovr_jtag_pkg.
REQ-032 The sub-module spi_hdr_counter (loadable down-counter with zero detect) is the single natural split; the remainder is flat.
REQ-033 No BSCAN or STARTUP primitive is instantiated inside the block; the wrapper connects them.

Verification
REQ-034 Capture, header 0x0008, 8 shifts of 0xA5, update -> spi_csn low for exactly 8 cycles, 8 sck_en pulses, mosi sequence 1,0,1,0,0,1,0,1, then DONE.
REQ-035 Header 0x0010 with miso driving 0x9F3C -> jtag_tdo returns 0x9F3C LSB-first, spi_csn rises on the 16th payload edge, and 4 extra shifts give no sck_en.
REQ-036 Header 0x0000 -> spi_csn never goes low, and sck_en stays 0 through 32 subsequent shifts.
REQ-037 Header 0x0020, update after 10 payload bits -> spi_csn=1 and abort_err=1 at that edge; the next capture clears abort_err.
REQ-038 rst_n pulled low mid-XFER, between clock edges -> spi_csn=1 asynchronously, state IDLE; after release, shifts without capture give no sck_en.
REQ-039 jtag_sel=0 with capture/shift/update toggling -> no state change and all outputs at their idle values.
